// File: rtl/set_assoc_cache.sv
// Set-associative write-back cache with LRU or FIFO replacement.
// Line fill/writeback through a level/grant memory port, plus full flush.
module set_assoc_cache #(
  parameter int LINE_ADDR_LEN  = 3,
  parameter int SET_ADDR_LEN   = 3,
  parameter int TAG_ADDR_LEN   = 7,
  parameter int WAY_CNT        = 4,
  parameter int REPLACE_POLICY = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [31:0]                           addr,
  input  logic                                  rd_req,
  input  logic                                  wr_req,
  input  logic [31:0]                           wr_data,
  output logic [31:0]                           rd_data,
  output logic                                  miss,
  input  logic                                  flush_req,
  output logic                                  flush_done,
  output logic [TAG_ADDR_LEN+SET_ADDR_LEN-1:0]  mem_addr,
  output logic                                  mem_rd_req,
  output logic                                  mem_wr_req,
  input  logic                                  mem_gnt,
  input  logic [32*(1<<LINE_ADDR_LEN)-1:0]      mem_rd_line,
  output logic [32*(1<<LINE_ADDR_LEN)-1:0]      mem_wr_line
);

  localparam int WORDS  = 1 << LINE_ADDR_LEN;
  localparam int SETS   = 1 << SET_ADDR_LEN;
  localparam int WAY_W  = $clog2(WAY_CNT);
  localparam int LINE_W = 32 * WORDS;
  localparam int MA_W   = TAG_ADDR_LEN + SET_ADDR_LEN;
  localparam int IDX_W  = SET_ADDR_LEN + WAY_W;
  localparam int SET_LO = LINE_ADDR_LEN + 2;
  localparam int TAG_LO = SET_LO + SET_ADDR_LEN;
  localparam int A_HI   = TAG_LO + TAG_ADDR_LEN;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWAP_OUT,
    S_SWAP_IN,
    S_SWAP_IN_OK,
    S_FLUSH_SCAN,
    S_FLUSH_WB
  } state_t;

  state_t                  r_state;
  logic [LINE_W-1:0]       r_line  [SETS][WAY_CNT];
  logic [TAG_ADDR_LEN-1:0] r_tag   [SETS][WAY_CNT];
  logic [WAY_CNT-1:0]      r_valid [SETS];
  logic [WAY_CNT-1:0]      r_dirty [SETS];
  logic [WAY_W-1:0]        r_age   [SETS][WAY_CNT];
  logic [WAY_W-1:0]        r_fifo  [SETS];

  logic [SET_ADDR_LEN-1:0] r_set;
  logic [TAG_ADDR_LEN-1:0] r_req_tag;
  logic [WAY_W-1:0]        r_vic;
  logic [LINE_W-1:0]       r_fill;
  logic [LINE_W-1:0]       r_wb_line;
  logic [IDX_W-1:0]        r_scan;
  logic [31:0]             r_rd_data;
  logic                    r_mem_rd_req;
  logic                    r_mem_wr_req;
  logic                    r_flush_done;
  logic [MA_W-1:0]         r_mem_addr;

  logic [LINE_ADDR_LEN-1:0] w_word;
  logic [SET_ADDR_LEN-1:0]  w_set;
  logic [TAG_ADDR_LEN-1:0]  w_tag;
  logic                     w_rd;
  logic                     w_wr;
  logic                     w_req;
  logic                     w_idle;
  logic                     w_hit;
  logic [WAY_W-1:0]         w_hit_way;
  logic                     w_inv_found;
  logic [WAY_W-1:0]         w_inv_way;
  logic [WAY_W-1:0]         w_lru_way;
  logic [WAY_W-1:0]         w_victim;
  logic [LINE_W-1:0]        w_hit_line;
  logic [31:0]              w_rd_word;
  logic [SET_ADDR_LEN-1:0]  w_scan_set;
  logic [WAY_W-1:0]         w_scan_way;
  logic                     w_scan_last;
  logic                     w_touch;
  logic [SET_ADDR_LEN-1:0]  w_touch_set;
  logic [WAY_W-1:0]         w_touch_way;
  logic                     w_fill;
  logic                     w_unused;

  assign w_word   = addr[SET_LO-1:2];
  assign w_set    = addr[TAG_LO-1:SET_LO];
  assign w_tag    = addr[A_HI-1:TAG_LO];
  assign w_unused = ^{addr[31:A_HI], addr[1:0]};

  assign w_rd   = rd_req;
  assign w_wr   = wr_req & ~rd_req;
  assign w_req  = rd_req | wr_req;
  assign w_idle = (r_state == S_IDLE);

  assign w_hit_line = r_line[w_set][w_hit_way];
  assign w_rd_word  = w_hit_line[{w_word, 5'd0} +: 32];

  assign w_scan_set  = r_scan[IDX_W-1:WAY_W];
  assign w_scan_way  = r_scan[WAY_W-1:0];
  assign w_scan_last = &r_scan;

  assign w_fill      = (r_state == S_SWAP_IN_OK);
  assign w_touch     = (w_idle & w_req & w_hit) | w_fill;
  assign w_touch_set = w_fill ? r_set : w_set;
  assign w_touch_way = w_fill ? r_vic : w_hit_way;

  assign miss        = w_req & ~(w_hit & w_idle);
  assign rd_data     = r_rd_data;
  assign mem_addr    = r_mem_addr;
  assign mem_rd_req  = r_mem_rd_req;
  assign mem_wr_req  = r_mem_wr_req;
  assign mem_wr_line = r_wb_line;
  assign flush_done  = r_flush_done;

  // Tag lookup: lowest matching valid way wins
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int i = WAY_CNT - 1; i >= 0; i--) begin
      if (r_valid[w_set][i] && r_tag[w_set][i] == w_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(i);
      end
    end
  end

  // Victim choice: free way first, then the policy way
  always_comb begin
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    w_lru_way   = '0;
    for (int i = WAY_CNT - 1; i >= 0; i--) begin
      if (!r_valid[w_set][i]) begin
        w_inv_found = 1'b1;
        w_inv_way   = WAY_W'(i);
      end
      if (r_age[w_set][i] == WAY_W'(WAY_CNT - 1)) begin
        w_lru_way = WAY_W'(i);
      end
    end
    if (w_inv_found) begin
      w_victim = w_inv_way;
    end else if (REPLACE_POLICY != 0) begin
      w_victim = r_fifo[w_set];
    end else begin
      w_victim = w_lru_way;
    end
  end

  // Line data and tags; only touched by fills and write hits
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_line[r_set][r_vic] <= r_fill;
      r_tag[r_set][r_vic]  <= r_req_tag;
    end else if (w_idle && w_hit && w_wr) begin
      r_line[w_set][w_hit_way][{w_word, 5'd0} +: 32] <= wr_data;
    end
  end

  // Replacement bookkeeping: ages age on hit/fill, FIFO moves on fill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_fifo[s] <= '0;
        for (int w = 0; w < WAY_CNT; w++) begin
          r_age[s][w] <= WAY_W'(w);
        end
      end
    end else begin
      if (w_touch && REPLACE_POLICY == 0) begin
        for (int i = 0; i < WAY_CNT; i++) begin
          if (r_age[w_touch_set][i] < r_age[w_touch_set][w_touch_way]) begin
            r_age[w_touch_set][i] <= r_age[w_touch_set][i] + 1'b1;
          end
        end
        r_age[w_touch_set][w_touch_way] <= '0;
      end
      if (w_fill && REPLACE_POLICY != 0) begin
        r_fifo[r_set] <= r_fifo[r_set] + 1'b1;
      end
    end
  end

  // Main controller: hits, miss handling, flush walk, memory port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_set        <= '0;
      r_req_tag    <= '0;
      r_vic        <= '0;
      r_fill       <= '0;
      r_wb_line    <= '0;
      r_scan       <= '0;
      r_rd_data    <= '0;
      r_mem_rd_req <= 1'b0;
      r_mem_wr_req <= 1'b0;
      r_mem_addr   <= '0;
      r_flush_done <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
      end
    end else begin
      r_flush_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_hit) begin
              if (w_rd) begin
                r_rd_data <= w_rd_word;
              end else begin
                r_dirty[w_set][w_hit_way] <= 1'b1;
              end
            end else begin
              r_set     <= w_set;
              r_req_tag <= w_tag;
              r_vic     <= w_victim;
              if (r_valid[w_set][w_victim] && r_dirty[w_set][w_victim]) begin
                r_state      <= S_SWAP_OUT;
                r_mem_wr_req <= 1'b1;
                r_mem_addr   <= {r_tag[w_set][w_victim], w_set};
                r_wb_line    <= r_line[w_set][w_victim];
              end else begin
                r_state      <= S_SWAP_IN;
                r_mem_rd_req <= 1'b1;
                r_mem_addr   <= {w_tag, w_set};
              end
            end
          end else if (flush_req) begin
            r_state <= S_FLUSH_SCAN;
            r_scan  <= '0;
          end
        end
        S_SWAP_OUT: begin
          if (mem_gnt) begin
            r_state      <= S_SWAP_IN;
            r_mem_wr_req <= 1'b0;
            r_mem_rd_req <= 1'b1;
            r_mem_addr   <= {r_req_tag, r_set};
          end
        end
        S_SWAP_IN: begin
          if (mem_gnt) begin
            r_state      <= S_SWAP_IN_OK;
            r_mem_rd_req <= 1'b0;
            r_mem_addr   <= '0;
            r_fill       <= mem_rd_line;
          end
        end
        S_SWAP_IN_OK: begin
          r_valid[r_set][r_vic] <= 1'b1;
          r_dirty[r_set][r_vic] <= 1'b0;
          r_state               <= S_IDLE;
        end
        S_FLUSH_SCAN: begin
          if (r_valid[w_scan_set][w_scan_way] &&
              r_dirty[w_scan_set][w_scan_way]) begin
            r_state      <= S_FLUSH_WB;
            r_mem_wr_req <= 1'b1;
            r_mem_addr   <= {r_tag[w_scan_set][w_scan_way], w_scan_set};
            r_wb_line    <= r_line[w_scan_set][w_scan_way];
          end else if (w_scan_last) begin
            r_state      <= S_IDLE;
            r_flush_done <= 1'b1;
          end else begin
            r_scan <= r_scan + 1'b1;
          end
        end
        S_FLUSH_WB: begin
          if (mem_gnt) begin
            r_dirty[w_scan_set][w_scan_way] <= 1'b0;
            r_mem_wr_req <= 1'b0;
            r_mem_addr   <= '0;
            if (w_scan_last) begin
              r_state      <= S_IDLE;
              r_flush_done <= 1'b1;
            end else begin
              r_state <= S_FLUSH_SCAN;
              r_scan  <= r_scan + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache: one LRU and one FIFO instance,
// a line-addressed memory model and per-scenario checking tasks.
module tb_set_assoc_cache;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         rd_req;
  logic         wr_req;
  logic         flush_req;
  logic         mem_gnt;
  logic [31:0]  addr;
  logic [31:0]  wr_data;
  logic [255:0] mem_rd_line;
  bit           u;

  logic [31:0]  a_rd_data, b_rd_data;
  logic         a_miss, b_miss;
  logic         a_flush_done, b_flush_done;
  logic [9:0]   a_mem_addr, b_mem_addr;
  logic         a_mem_rd_req, b_mem_rd_req;
  logic         a_mem_wr_req, b_mem_wr_req;
  logic [255:0] a_mem_wr_line, b_mem_wr_line;

  logic [31:0]  o_rd_data;
  logic         o_miss;
  logic         o_flush_done;
  logic [9:0]   o_mem_addr;
  logic         o_mem_rd_req;
  logic         o_mem_wr_req;
  logic [255:0] o_mem_wr_line;

  assign o_rd_data     = u ? b_rd_data     : a_rd_data;
  assign o_miss        = u ? b_miss        : a_miss;
  assign o_flush_done  = u ? b_flush_done  : a_flush_done;
  assign o_mem_addr    = u ? b_mem_addr    : a_mem_addr;
  assign o_mem_rd_req  = u ? b_mem_rd_req  : a_mem_rd_req;
  assign o_mem_wr_req  = u ? b_mem_wr_req  : a_mem_wr_req;
  assign o_mem_wr_line = u ? b_mem_wr_line : a_mem_wr_line;

  set_assoc_cache #(.REPLACE_POLICY(0)) u_lru (
    .clk(clk), .rst(rst), .addr(addr),
    .rd_req(rd_req & ~u), .wr_req(wr_req & ~u),
    .wr_data(wr_data), .rd_data(a_rd_data), .miss(a_miss),
    .flush_req(flush_req & ~u), .flush_done(a_flush_done),
    .mem_addr(a_mem_addr), .mem_rd_req(a_mem_rd_req),
    .mem_wr_req(a_mem_wr_req), .mem_gnt(mem_gnt & ~u),
    .mem_rd_line(mem_rd_line), .mem_wr_line(a_mem_wr_line)
  );

  set_assoc_cache #(.REPLACE_POLICY(1)) u_fifo (
    .clk(clk), .rst(rst), .addr(addr),
    .rd_req(rd_req & u), .wr_req(wr_req & u),
    .wr_data(wr_data), .rd_data(b_rd_data), .miss(b_miss),
    .flush_req(flush_req & u), .flush_done(b_flush_done),
    .mem_addr(b_mem_addr), .mem_rd_req(b_mem_rd_req),
    .mem_wr_req(b_mem_wr_req), .mem_gnt(mem_gnt & u),
    .mem_rd_line(mem_rd_line), .mem_wr_line(b_mem_wr_line)
  );

  int checks = 0;
  int fails  = 0;

  logic [255:0] mem [logic [9:0]];
  logic [9:0]   ev_addr [$];
  bit           ev_wr   [$];
  logic [31:0]  ev_w1   [$];
  int           req_cycles;
  int           gnt_gap;

  function automatic logic [255:0] mline(input logic [9:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) begin
      l[32*k +: 32] = 32'hC000_0000 | (32'(a) << 8) | 32'(k);
    end
    return l;
  endfunction

  function automatic logic [255:0] fetch(input logic [9:0] a);
    if (mem.exists(a)) return mem[a];
    return mline(a);
  endfunction

  task automatic clear_log;
    ev_addr.delete();
    ev_wr.delete();
    ev_w1.delete();
  endtask

  task automatic do_reset;
    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
    flush_req = 1'b0; mem_gnt = 1'b0;
    addr = '0; wr_data = '0; mem_rd_line = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mem.delete();
    clear_log();
  endtask

  task automatic access(input logic [31:0] a, input bit wr,
                        input logic [31:0] d, input int gdly,
                        output logic [31:0] rdat, output bit was_miss);
    int cnt;
    int last_g;
    bit done;
    logic [31:0] rd0;
    cnt = 0; last_g = -100; done = 1'b0;
    was_miss = 1'b0; req_cycles = 0; gnt_gap = -1;
    @(negedge clk);
    addr = a; wr_data = d; rd_req = ~wr; wr_req = wr; mem_gnt = 1'b0;
    #1;
    rd0 = o_rd_data;
    for (int i = 0; i < 400 && !done; i++) begin
      checks++;
      if ((o_mem_rd_req && o_mem_wr_req) ||
          (!o_mem_rd_req && !o_mem_wr_req && o_mem_addr !== 10'd0)) begin
        fails++;
        $display("FAIL mem_bus a=%h rd=%0b wr=%0b addr=%h need exclusive reqs, addr 0 idle",
                 a, o_mem_rd_req, o_mem_wr_req, o_mem_addr);
      end
      if (!o_miss) begin
        done = 1'b1;
        gnt_gap = i - last_g;
      end else begin
        was_miss = 1'b1;
        checks++;
        if (o_rd_data !== rd0) begin
          fails++;
          $display("FAIL rd_hold a=%h got %h need %h", a, o_rd_data, rd0);
        end
        if (o_mem_rd_req || o_mem_wr_req) begin
          if (o_mem_rd_req) req_cycles++;
          cnt++;
          if (cnt > gdly) begin
            cnt = 0;
            last_g = i;
            ev_wr.push_back(o_mem_wr_req);
            ev_addr.push_back(o_mem_addr);
            ev_w1.push_back(o_mem_wr_line[63:32]);
            if (o_mem_wr_req) mem[o_mem_addr] = o_mem_wr_line;
            else mem_rd_line = fetch(o_mem_addr);
            mem_gnt = 1'b1;
          end
        end
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
      end
    end
    checks++;
    if (!done) begin
      fails++;
      $display("FAIL access_timeout a=%h miss still %0b need 0", a, o_miss);
    end
    @(negedge clk);
    rdat = o_rd_data;
    rd_req = 1'b0;
    wr_req = 1'b0;
  endtask

  task automatic run_flush(output int pulses);
    pulses = 0;
    @(negedge clk);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    #1;
    for (int i = 0; i < 80; i++) begin
      if (o_flush_done) pulses++;
      checks++;
      if (o_mem_rd_req) begin
        fails++;
        $display("FAIL flush_rd_req got 1 need 0 at cycle %0d", i);
      end
      if (o_mem_wr_req) begin
        ev_wr.push_back(1'b1);
        ev_addr.push_back(o_mem_addr);
        ev_w1.push_back(o_mem_wr_line[63:32]);
        mem[o_mem_addr] = o_mem_wr_line;
        mem_gnt = 1'b1;
      end
      @(negedge clk);
      mem_gnt = 1'b0;
      #1;
    end
  endtask

  task automatic test_reset;
    for (int k = 0; k < 2; k++) begin
      u = bit'(k);
      do_reset();
      #1;
      checks++;
      if (o_rd_data !== 32'd0 || o_miss !== 1'b0 || o_mem_rd_req !== 1'b0 ||
          o_mem_wr_req !== 1'b0 || o_flush_done !== 1'b0 || o_mem_addr !== 10'd0) begin
        fails++;
        $display("FAIL reset_state u=%0d rd=%h miss=%0b mrd=%0b mwr=%0b fd=%0b ma=%h need all 0",
                 k, o_rd_data, o_miss, o_mem_rd_req, o_mem_wr_req, o_flush_done, o_mem_addr);
      end
    end
    u = 1'b0;
  endtask

  task automatic test_cold_read;
    logic [31:0] r;
    bit m;
    u = 1'b0;
    do_reset();
    access(32'h104, 1'b0, '0, 0, r, m);
    checks++;
    if (m !== 1'b1) begin
      fails++; $display("FAIL cold_miss got %0b need 1", m);
    end
    checks++;
    if (ev_wr.size() != 1 || ev_wr[0] !== 1'b0 || ev_addr[0] !== 10'h08) begin
      fails++; $display("FAIL cold_traffic n=%0d need one read of 08", ev_wr.size());
    end
    checks++;
    if (gnt_gap != 2) begin
      fails++; $display("FAIL cold_gnt_gap got %0d need 2", gnt_gap);
    end
    checks++;
    if (r !== 32'hC000_0801) begin
      fails++; $display("FAIL cold_data got %h need C0000801", r);
    end
    access(32'h11C, 1'b0, '0, 0, r, m);
    checks++;
    if (m !== 1'b0 || r !== 32'hC000_0807) begin
      fails++; $display("FAIL hit_word7 got miss=%0b %h need 0 C0000807", m, r);
    end
    @(negedge clk);
    addr = 32'h104; rd_req = 1'b1; wr_req = 1'b1; wr_data = 32'h55;
    @(negedge clk);
    checks++;
    if (o_rd_data !== 32'hC000_0801) begin
      fails++; $display("FAIL both_req_read got %h need C0000801", o_rd_data);
    end
    rd_req = 1'b0; wr_req = 1'b0;
    access(32'h104, 1'b0, '0, 0, r, m);
    checks++;
    if (r !== 32'hC000_0801) begin
      fails++; $display("FAIL both_req_nowrite got %h need C0000801", r);
    end
  endtask

  task automatic test_policy(input bit pol);
    logic [31:0] r;
    bit m;
    u = pol;
    do_reset();
    access(32'h100, 1'b0, '0, 0, r, m);
    access(32'h200, 1'b0, '0, 0, r, m);
    access(32'h300, 1'b0, '0, 0, r, m);
    access(32'h400, 1'b0, '0, 0, r, m);
    access(32'h100, 1'b0, '0, 0, r, m);
    checks++;
    if (m !== 1'b0) begin
      fails++; $display("FAIL pol%0d_reread miss got %0b need 0", pol, m);
    end
    clear_log();
    access(32'h500, 1'b0, '0, 0, r, m);
    checks++;
    if (m !== 1'b1 || r !== 32'hC000_2800 || ev_wr.size() != 1) begin
      fails++; $display("FAIL pol%0d_fill500 miss=%0b data=%h n=%0d need 1 C0002800 1",
                        pol, m, r, ev_wr.size());
    end
    access(32'h200, 1'b0, '0, 0, r, m);
    checks++;
    if (m !== ~pol) begin
      fails++; $display("FAIL pol%0d_tag2 miss got %0b need %0b", pol, m, ~pol);
    end
    access(32'h100, 1'b0, '0, 0, r, m);
    checks++;
    if (m !== pol) begin
      fails++; $display("FAIL pol%0d_tag1 miss got %0b need %0b", pol, m, pol);
    end
    u = 1'b0;
  endtask

  task automatic test_write_evict;
    logic [31:0] r;
    bit m;
    u = 1'b0;
    do_reset();
    access(32'h104, 1'b0, '0, 0, r, m);
    access(32'h104, 1'b1, 32'hDEAD_BEEF, 0, r, m);
    checks++;
    if (m !== 1'b0) begin
      fails++; $display("FAIL wr_hit miss got %0b need 0", m);
    end
    access(32'h104, 1'b0, '0, 0, r, m);
    checks++;
    if (r !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL wr_readback got %h need DEADBEEF", r);
    end
    access(32'h200, 1'b0, '0, 0, r, m);
    access(32'h300, 1'b0, '0, 0, r, m);
    access(32'h400, 1'b0, '0, 0, r, m);
    clear_log();
    access(32'h500, 1'b0, '0, 0, r, m);
    checks++;
    if (ev_wr.size() != 2 || ev_wr[0] !== 1'b1 || ev_addr[0] !== 10'h08 ||
        ev_w1[0] !== 32'hDEAD_BEEF || ev_wr[1] !== 1'b0 || ev_addr[1] !== 10'h28) begin
      fails++; $display("FAIL evict_seq n=%0d need wr 08 DEADBEEF then rd 28", ev_wr.size());
    end
    clear_log();
    access(32'h104, 1'b0, '0, 0, r, m);
    checks++;
    if (m !== 1'b1 || r !== 32'hDEAD_BEEF || ev_wr.size() != 1) begin
      fails++; $display("FAIL evict_refetch miss=%0b data=%h n=%0d need 1 DEADBEEF 1",
                        m, r, ev_wr.size());
    end
  endtask

  task automatic test_flush;
    logic [31:0] r;
    bit m;
    int p;
    u = 1'b0;
    do_reset();
    access(32'h104, 1'b1, 32'hDEAD_BEEF, 0, r, m);
    checks++;
    if (m !== 1'b1) begin
      fails++; $display("FAIL wr_miss miss got %0b need 1", m);
    end
    access(32'h268, 1'b1, 32'h1234_5678, 0, r, m);
    access(32'h120, 1'b0, '0, 0, r, m);
    checks++;
    if (r !== 32'hC000_0900) begin
      fails++; $display("FAIL clean_read got %h need C0000900", r);
    end
    clear_log();
    run_flush(p);
    checks++;
    if (p != 1) begin
      fails++; $display("FAIL flush_done_pulses got %0d need 1", p);
    end
    checks++;
    if (ev_wr.size() != 2 || ev_addr[0] !== 10'h08 || ev_addr[1] !== 10'h13 ||
        ev_w1[0] !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL flush_order n=%0d need writes 08 then 13", ev_wr.size());
    end
    r = fetch(10'h13) >> 64;
    checks++;
    if (r !== 32'h1234_5678) begin
      fails++; $display("FAIL flush_data got %h need 12345678", r);
    end
    clear_log();
    access(32'h104, 1'b0, '0, 0, r, m);
    checks++;
    if (m !== 1'b0 || r !== 32'hDEAD_BEEF || ev_wr.size() != 0) begin
      fails++; $display("FAIL post_flush_s0 miss=%0b data=%h n=%0d need 0 DEADBEEF 0",
                        m, r, ev_wr.size());
    end
    access(32'h268, 1'b0, '0, 0, r, m);
    checks++;
    if (m !== 1'b0 || r !== 32'h1234_5678 || ev_wr.size() != 0) begin
      fails++; $display("FAIL post_flush_s3 miss=%0b data=%h n=%0d need 0 12345678 0",
                        m, r, ev_wr.size());
    end
    run_flush(p);
    checks++;
    if (p != 1 || ev_wr.size() != 0) begin
      fails++; $display("FAIL reflush pulses=%0d writes=%0d need 1 0", p, ev_wr.size());
    end
  endtask

  task automatic test_rst_mid;
    logic [31:0] r;
    bit m;
    bit seen;
    u = 1'b0;
    do_reset();
    @(negedge clk);
    addr = 32'h104; rd_req = 1'b1;
    #1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (o_mem_rd_req) seen = 1'b1;
      else begin
        @(negedge clk);
        #1;
      end
    end
    checks++;
    if (!seen) begin
      fails++; $display("FAIL rst_mid_setup mem_rd_req got 0 need 1");
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (o_mem_rd_req !== 1'b0 || o_mem_addr !== 10'd0) begin
      fails++; $display("FAIL rst_mid_req got rd=%0b addr=%h need 0 0", o_mem_rd_req, o_mem_addr);
    end
    @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    access(32'h104, 1'b0, '0, 0, r, m);
    checks++;
    if (m !== 1'b1 || r !== 32'hC000_0801) begin
      fails++; $display("FAIL rst_mid_reread miss=%0b data=%h need 1 C0000801", m, r);
    end
  endtask

  task automatic test_slow_gnt;
    logic [31:0] r;
    bit m;
    u = 1'b0;
    do_reset();
    access(32'h104, 1'b0, '0, 0, r, m);
    access(32'h3A0, 1'b0, '0, 50, r, m);
    checks++;
    if (m !== 1'b1 || req_cycles != 51) begin
      fails++; $display("FAIL slow_req miss=%0b req_cycles=%0d need 1 51", m, req_cycles);
    end
    checks++;
    if (r !== 32'hC000_1D00) begin
      fails++; $display("FAIL slow_data got %h need C0001D00", r);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    u = 1'b0;
    test_reset();
    test_cold_read();
    test_policy(1'b0);
    test_policy(1'b1);
    test_write_evict();
    test_flush();
    test_rst_mid();
    test_slow_gnt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
